// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame FSM encodings and a parity helper.
// Intended to be shared with the matching receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity bit for up to 9 payload bits (unused upper bits must be zero).
    // Even parity makes the total count of ones even, odd makes it odd.
    function automatic logic parity_bit(input logic [8:0] payload, input int mode);
        logic red_s;
        logic res_s;
        red_s = ^payload;
        case (mode)
            PARITY_ODD:  res_s = ~red_s;
            PARITY_EVEN: res_s = red_s;
            default:     res_s = 1'b0;
        endcase
        return res_s;
    endfunction

endpackage

// File: rtl/uart_tx_param_baud_tick_gen.sv
// One-cycle baud enable generator. The counter restarts from zero on clear and
// runs 0..DIV-1 while enabled; tick is high during the last cycle of each bit time.
// The tick is registered: it is raised on the edge that moves the counter onto DIV-1.
module baud_tick_gen #(
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

    generate
        if (DIV < 2) begin : g_param_error
            $error("baud_tick_gen: CLOCK_RATE/BAUD_RATE must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Bit-time counter: restart on clear, wrap at DIV-1, hold while disabled
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered tick: asserted for the cycle in which the counter sits at DIV-1
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= ~clear & enable & (cnt_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS payload LSB first,
// optional parity, one or two stop bits. Ready/valid load, registered tx line.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 7,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 new_data,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx
);

    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    generate
        if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_error
            $error("uart_tx_param: illegal parameter combination");
        end
    endgenerate

    uart_state_e          state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [BCW-1:0]       bit_cnt_r;
    logic                 parity_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 ready_r;
    logic                 accept_s;
    logic                 tick_s;

    assign accept_s = new_data & ready_r;

    baud_tick_gen #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE)
    ) u_baud (
        .clk    (clk),
        .rstN   (rstN),
        .clear  (accept_s),
        .enable (busy_r),
        .tick   (tick_s)
    );

    // Frame sequencer: owns state, shift register, bit counter and all outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            parity_r  <= 1'b0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shift_r   <= data;
                        parity_r  <= parity_bit(9'(data), PARITY);
                        bit_cnt_r <= '0;
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
                        ready_r   <= 1'b0;
                        state_r   <= ST_START;
                    end else begin
                        tx_r      <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        tx_r      <= shift_r[0];
                        bit_cnt_r <= '0;
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= '0;
                            if (PARITY != PARITY_NONE) begin
                                tx_r    <= parity_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            // next payload bit is already sitting in position 1
                            tx_r      <= shift_r[1];
                            shift_r   <= shift_r >> 1;
                            bit_cnt_r <= bit_cnt_r + BCW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_s) begin
                        tx_r      <= 1'b1;
                        bit_cnt_r <= '0;
                        state_r   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        if (bit_cnt_r == STOP_LAST) begin
                            busy_r  <= 1'b0;
                            ready_r <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BCW'(1);
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= '0;
                    tx_r      <= 1'b1;
                    busy_r    <= 1'b0;
                    ready_r   <= 1'b1;
                end
            endcase
        end
    end

    assign tx    = tx_r;
    assign busy  = busy_r;
    assign ready = ready_r;

endmodule
